// File: rtl/fp_norm_round_if.sv
// Beat bus between the leading-zero predictor stage and the normalize/round block.
interface fp_norm_round_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_sum;
   logic [4:0]  in_shift_bits;
   logic        in_shift_right;
   logic [7:0]  in_exp;
   logic        in_sign;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_underflow;
   logic        out_inexact;

   modport master (
      output in_valid, in_sum, in_shift_bits, in_shift_right, in_exp, in_sign, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
   );

   modport slave (
      input  in_valid, in_sum, in_shift_bits, in_shift_right, in_exp, in_sign, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
   );
endinterface

// File: rtl/fp_norm_round.sv
// binary32 normalize / round-to-nearest-even / pack, two-stage elastic pipeline.
module fp_norm_round (
   input logic            clk,
   input logic            rst,
   fp_norm_round_if.slave io
);
   localparam int STAGES = 2;

   typedef struct packed {
      logic [31:0] sum;
      logic [4:0]  sh;
      logic        rgt;
      logic [7:0]  ex;
      logic        sg;
   } s1_t;

   typedef struct packed {
      logic [23:0] n;
      logic [9:0]  e;
      logic        sticky;
      logic        sg;
      logic        zero;
   } s2_t;

   logic [STAGES:1] vld_pipe_q;
   s1_t             s1_q;
   s2_t             s2_q, s2_d;
   logic            s1_adv, s1_load;

   assign s1_adv      = !vld_pipe_q[2] | io.out_ready;
   assign io.in_ready = !vld_pipe_q[1] | s1_adv;
   assign s1_load     = io.in_valid & io.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe_q <= '0;
      end else begin
         if (io.in_ready) vld_pipe_q[1] <= io.in_valid;
         if (s1_adv)      vld_pipe_q[2] <= vld_pipe_q[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
      end else if (s1_load) begin
         s1_q <= '{sum: io.in_sum, sh: io.in_shift_bits, rgt: io.in_shift_right,
                   ex: io.in_exp, sg: io.in_sign};
      end
   end

   // S1: align the leading one to bit 24, fixing a one-short left shift.
   logic [31:0] mask;
   logic [24:0] n_sh;
   logic [9:0]  e_sh;
   logic        stk;

   always_comb begin
      mask = (32'd1 << s1_q.sh) - 32'd1;
      n_sh = '0;
      e_sh = '0;
      stk  = 1'b0;
      if (s1_q.rgt) begin
         n_sh = 25'(s1_q.sum >> s1_q.sh);
         stk  = |(s1_q.sum & mask);
         e_sh = {2'b00, s1_q.ex} + {5'd0, s1_q.sh};
      end else begin
         n_sh = 25'(s1_q.sum << s1_q.sh);
         e_sh = {2'b00, s1_q.ex} - {5'd0, s1_q.sh};
         if (!n_sh[24] && n_sh[23]) begin
            n_sh = n_sh << 1;
            e_sh = e_sh - 10'd1;
         end
      end
      s2_d.n      = n_sh[23:0];
      s2_d.e      = e_sh;
      s2_d.sticky = stk;
      s2_d.sg     = s1_q.sg;
      s2_d.zero   = (s1_q.sum == 32'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_q <= '0;
      end else if (s1_adv && vld_pipe_q[1]) begin
         s2_q <= s2_d;
      end
   end

   // S2: round and pack; outputs are gated so nothing leaks while the stage is empty.
   logic        inc;
   logic [23:0] frac_r;
   logic [9:0]  e_r;
   logic [31:0] res;
   logic        ovf, unf, inx;

   always_comb begin
      inc    = s2_q.n[0] & (s2_q.sticky | s2_q.n[1]);
      frac_r = {1'b0, s2_q.n[23:1]} + {23'd0, inc};
      e_r    = s2_q.e + {9'd0, frac_r[23]};
      res    = '0;
      ovf    = 1'b0;
      unf    = 1'b0;
      inx    = 1'b0;
      if (!vld_pipe_q[2] || s2_q.zero) begin
         res = '0;
      end else if ($signed(e_r) >= 10'sd255) begin
         res = {s2_q.sg, 8'hFF, 23'h0};
         ovf = 1'b1;
         inx = 1'b1;
      end else if ($signed(e_r) <= 10'sd0) begin
         res = {s2_q.sg, 31'h0};
         unf = 1'b1;
         inx = 1'b1;
      end else begin
         res = {s2_q.sg, e_r[7:0], frac_r[22:0]};
         inx = s2_q.n[0] | s2_q.sticky;
      end
   end

   assign io.out_valid     = vld_pipe_q[2];
   assign io.out_result    = res;
   assign io.out_overflow  = ovf;
   assign io.out_underflow = unf;
   assign io.out_inexact   = inx;
endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The ports SHALL be as follows.
  - clk  input  1  : rising-edge clock.
  - rst  input  1  : asynchronous, active-high reset.
  - in_valid  input  1  : input beat valid.
  - in_ready  output  1  : module can accept a beat.
  - in_sum  input  32  : raw adder magnitude from the leading-zero predictor stage (nominal leading one at bit 24).
  - in_shift_bits  input  5  : shift amount from the leading-zero predictor.
  - in_shift_right  input  1  : 1 = right shift by in_shift_bits; 0 = left shift.
  - in_exp  input  8  : biased exponent of the larger operand.
  - in_sign  input  1  : result sign.
  - out_valid  output  1  : output beat valid.
  - out_ready  input  1  : downstream accepts the beat.
  - out_result  output  32  : IEEE-754 binary32 result.
  - out_overflow  output  1  : result overflowed to infinity.
  - out_underflow  output  1  : result was flushed to zero.
  - out_inexact  output  1  : rounding discarded nonzero bits.

Function
REQ-003 The datapath SHALL be a 2-stage pipeline.
  - S1: register inputs, then shift.
  - S2: round and pack.
  - Latency: exactly 2 cycles from input handshake to out_valid when unstalled.
REQ-004 Handshake rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_result and flags SHALL hold stable while out_valid & !out_ready.
REQ-005 in_ready SHALL equal !s1_valid | s1_advance; s1_advance = !s2_valid | out_ready. This gives full throughput of 1 beat/cycle and no combinational path from in_valid to in_ready.
REQ-006 Stalling SHALL lose no beat, duplicate no beat, and preserve order. Simultaneous accept and emit in the same cycle SHALL be legal.
REQ-007 S1 normalize:
  - When in_shift_right=1: n = in_sum >> in_shift_bits; sticky = OR of the shifted-out bits; e = in_exp + in_shift_bits.
  - When in_shift_right=0: n = in_sum << in_shift_bits; sticky = 0; e = in_exp - in_shift_bits.
  - e SHALL be computed as a 10-bit signed value.
REQ-008 S1 predictor-error correction: if n[24]=0 and n[23]=1 after the left shift, n SHALL be shifted left one more place and e decremented by 1.
REQ-009 Rounding field split after normalization: fraction = n[23:1]; guard = n[0]; sticky per REQ-007.
REQ-010 S2 SHALL round to nearest, ties to even: increment when guard & (sticky | fraction[0]).
REQ-011 Rounding carry-out SHALL set fraction = 0 and e = e + 1.
REQ-012 Exponent boundaries, applied after rounding:
  - e >= 255: out_result = {sign, 8'hFF, 23'h0}; out_overflow=1; out_inexact=1.
  - e <= 0: out_result = {sign, 31'h0}; out_underflow=1; out_inexact=1 (subnormals flushed).
REQ-013 in_sum == 0 SHALL produce out_result = 32'h00000000 with all flags 0, regardless of in_sign and in_exp.
REQ-014 Otherwise out_result SHALL be {sign, e[7:0], fraction}, and out_inexact SHALL equal guard | sticky.
REQ-015 in_shift_bits and in_exp SHALL be ignored when in_sum == 0.

Reset
REQ-016 While rst=1: out_valid=0, out_result=0, all flags=0, internal valid bits=0; in_ready SHALL be 1 from the first clock edge after reset deassertion.
REQ-017 Reset asserted mid-operation SHALL discard in-flight beats immediately (asynchronously); no stale beat SHALL appear after release.

Verification
REQ-018 Unity: in_sum=32'h01000000, shift=0/left, exp=127, sign=0 -> out_result=32'h3F800000 two cycles later, all flags 0.
REQ-019 Right shift: in_sum=32'h02000000, shift_bits=1, shift_right=1, exp=127 -> 32'h40000000. Overflow: same beat with exp=254 -> 32'h7F800000, out_overflow=1.
REQ-020 Rounding:
  - in_sum=32'h01000003, exp=127 -> 32'h3F800002, inexact=1.
  - in_sum=32'h01000001 (tie, even) -> 32'h3F800000, inexact=1.
REQ-021 Predictor error: in_sum=32'h00800000, shift_bits=0, left, exp=127 -> 32'h3F000000. Underflow: in_sum=32'h00000100, shift_bits=16, left, exp=10 -> 32'h00000000, out_underflow=1.
REQ-022 Back-pressure:
  - Stimulus: out_ready=0 for 4 cycles while streaming 4 beats.
  - Required: in_ready falls after 2 beats are accepted; on release, outputs emerge in order, unchanged, one per cycle.
  - Reset asserted during the stall: out_valid=0 immediately; no beat is emitted after release.
